// File: rtl/ram64_pkg.sv
// Shared constants, FSM state encoding and length saturation helper for the
// RAM64 fill/verify engine.
package ram64_pkg;

  localparam int ADDRESS_WIDTH = 6;
  localparam int DATA_WIDTH    = 16;
  localparam int DEPTH         = 64;
  localparam int LEN_WIDTH     = ADDRESS_WIDTH + 1;

  localparam logic [LEN_WIDTH-1:0] MAX_LEN = 7'd64;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WRITE  = 2'd1,
    S_VERIFY = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Requested word counts above the RAM depth are clamped to a full pass.
  function automatic logic [LEN_WIDTH-1:0] sat_len(input logic [LEN_WIDTH-1:0] len);
    if (len > MAX_LEN) begin
      return MAX_LEN;
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/ram64_pattern_gen.sv
// Running seed/step accumulator producing the arithmetic fill pattern.
// load re-seeds the accumulator; advance adds step (wraps mod 2^16).
module ram64_pattern_gen
  import ram64_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  advance,
  input  logic [DATA_WIDTH-1:0] load_value,
  input  logic [DATA_WIDTH-1:0] step,
  output logic [DATA_WIDTH-1:0] value
);

  // Accumulator register: load has priority over advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (advance) begin
      value <= value + step;
    end
  end

endmodule

// File: rtl/ram64_fill_ctrl.sv
// Fill / self-test sequencer driving RAM64 address, in and load.
// Writes word k = seed + k*step at base+k (mod 64) for a saturated length.
// Optional read-back pass is compiled in with RAM64_FILL_VERIFY_EN.
module ram64_fill_ctrl
  import ram64_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]     length,
  input  logic [DATA_WIDTH-1:0]    seed,
  input  logic [DATA_WIDTH-1:0]    step,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0]    ram_in,
  output logic                     ram_load,
  input  logic [DATA_WIDTH-1:0]    ram_out,
  output logic                     err,
  output logic [LEN_WIDTH-1:0]     mismatch_count
);

  state_t                   state, next_state;
  logic [ADDRESS_WIDTH-1:0] cfg_base;
  logic [LEN_WIDTH-1:0]     cfg_len;
  logic [DATA_WIDTH-1:0]    cfg_seed;
  logic [DATA_WIDTH-1:0]    cfg_step;
  logic [LEN_WIDTH-1:0]     word_idx, next_word_idx;
  logic [ADDRESS_WIDTH-1:0] next_address;
  logic                     next_busy, next_done, next_load;
  logic                     latch_cfg;
  logic                     pg_load, pg_advance;
  logic [DATA_WIDTH-1:0]    pg_load_value;
  logic                     last_word;

  assign last_word = (word_idx == (cfg_len - 7'd1));

  // The accumulator output is the registered ram_in and the verify reference.
  ram64_pattern_gen u_pattern (
    .clk        (clk),
    .reset      (reset),
    .load       (pg_load),
    .advance    (pg_advance),
    .load_value (pg_load_value),
    .step       (cfg_step),
    .value      (ram_in)
  );

  // State, counters, latched operation parameters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      ram_load    <= 1'b0;
      ram_address <= '0;
      word_idx    <= '0;
      cfg_base    <= '0;
      cfg_len     <= '0;
      cfg_seed    <= '0;
      cfg_step    <= '0;
    end else begin
      state       <= next_state;
      busy        <= next_busy;
      done        <= next_done;
      ram_load    <= next_load;
      ram_address <= next_address;
      word_idx    <= next_word_idx;
      if (latch_cfg) begin
        cfg_base <= base_addr;
        cfg_len  <= sat_len(length);
        cfg_seed <= seed;
        cfg_step <= step;
      end
    end
  end

  // Next-state and next-output decode; values describe the following cycle.
  always_comb begin
    next_state    = state;
    next_busy     = busy;
    next_done     = 1'b0;
    next_load     = 1'b0;
    next_address  = ram_address;
    next_word_idx = word_idx;
    latch_cfg     = 1'b0;
    pg_load       = 1'b0;
    pg_advance    = 1'b0;
    pg_load_value = cfg_seed;
    case (state)
      S_IDLE: begin
        next_busy = 1'b0;
        if (start) begin
          latch_cfg     = 1'b1;
          pg_load       = 1'b1;
          pg_load_value = seed;
          next_word_idx = '0;
          if (sat_len(length) == 7'd0) begin
            next_state = S_DONE;
            next_done  = 1'b1;
          end else begin
            next_state   = S_WRITE;
            next_busy    = 1'b1;
            next_load    = 1'b1;
            next_address = base_addr;
          end
        end else begin
          next_state = S_IDLE;
        end
      end
      S_WRITE: begin
        if (last_word) begin
          next_word_idx = '0;
`ifdef RAM64_FILL_VERIFY_EN
          pg_load       = 1'b1;
          next_state    = S_VERIFY;
          next_address  = cfg_base;
`else
          next_state    = S_DONE;
          next_busy     = 1'b0;
          next_done     = 1'b1;
`endif
        end else begin
          next_word_idx = word_idx + 7'd1;
          next_address  = ram_address + 6'd1;
          next_load     = 1'b1;
          pg_advance    = 1'b1;
        end
      end
`ifdef RAM64_FILL_VERIFY_EN
      S_VERIFY: begin
        if (last_word) begin
          next_state = S_DONE;
          next_busy  = 1'b0;
          next_done  = 1'b1;
        end else begin
          next_word_idx = word_idx + 7'd1;
          next_address  = ram_address + 6'd1;
          pg_advance    = 1'b1;
        end
      end
`endif
      S_DONE: begin
        next_state = S_IDLE;
        next_busy  = 1'b0;
      end
      default: begin
        next_state = S_IDLE;
        next_busy  = 1'b0;
      end
    endcase
  end

`ifdef RAM64_FILL_VERIFY_EN
  logic cmp_en;
  logic clear_status;

  assign cmp_en       = (state == S_VERIFY);
  assign clear_status = (state == S_IDLE) && start;

  // Sticky error flag and saturating mismatch counter for the read-back pass.
  always_ff @(posedge clk) begin
    if (reset || clear_status) begin
      err            <= 1'b0;
      mismatch_count <= '0;
    end else if (cmp_en && (ram_out != ram_in)) begin
      err <= 1'b1;
      if (mismatch_count != 7'h7F) begin
        mismatch_count <= mismatch_count + 7'd1;
      end
    end
  end
`else
  logic unused_inputs;

  assign err            = 1'b0;
  assign mismatch_count = 7'd0;
  assign unused_inputs  = ^{ram_out, cfg_base};
`endif

endmodule

// File: tb/tb_ram64_fill_ctrl.sv
// Self-checking bench for ram64_fill_ctrl with a behavioural RAM64 and a
// reference model of the expected memory image, latency and mismatch count.
module tb_ram64_fill_ctrl;
  import ram64_pkg::*;

`ifdef RAM64_FILL_VERIFY_EN
  localparam bit VERIFY_ON = 1'b1;
`else
  localparam bit VERIFY_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  base_addr;
  logic [6:0]  length;
  logic [15:0] seed;
  logic [15:0] step;
  logic        busy;
  logic        done;
  logic [5:0]  ram_address;
  logic [15:0] ram_in;
  logic        ram_load;
  logic [15:0] ram_out;
  logic        err;
  logic [6:0]  mismatch_count;

  logic [15:0] mem     [0:63];
  logic [15:0] exp_mem [0:63];
  bit          clear_mem;
  bit          inject;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  ram64_fill_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .base_addr      (base_addr),
    .length         (length),
    .seed           (seed),
    .step           (step),
    .busy           (busy),
    .done           (done),
    .ram_address    (ram_address),
    .ram_in         (ram_in),
    .ram_load       (ram_load),
    .ram_out        (ram_out),
    .err            (err),
    .mismatch_count (mismatch_count)
  );

  // Behavioural RAM64: synchronous write, combinational read.
  always @(posedge clk) begin
    if (clear_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= 16'h0000;
    end else if (ram_load) begin
      mem[ram_address] <= ram_in;
    end
  end

  assign ram_out = mem[ram_address] ^ ((inject && ram_address == 6'd3) ? 16'h0001 : 16'h0000);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < 64; i++) begin
      check($sformatf("%s mem[%0d]", tag, i), {16'h0000, mem[i]}, {16'h0000, exp_mem[i]});
    end
  endtask

  // One operation: build expectations, drive start, follow it to done (or reset).
  task automatic run_op(input string tag, input logic [5:0] b, input logic [6:0] l,
                        input logic [15:0] s, input logic [15:0] st,
                        input bit poke, input int rst_at);
    int   el, lat, cyc, loads, mism, exp_cnt;
    bit   seen_done, aborted;
    logic [5:0] a;

    el   = (l > 7'd64) ? 64 : int'(l);
    mism = 0;
    for (int i = 0; i < el; i++) begin
      a = b + 6'(i);
      if (rst_at < 0 || i < rst_at) exp_mem[a] = s + st * 16'(i);
      if (VERIFY_ON && inject && a == 6'd3) mism++;
    end
    exp_cnt = (mism > 127) ? 127 : mism;
    lat = (el == 0) ? 1 : (VERIFY_ON ? 2 * el + 1 : el + 1);

    @(negedge clk);
    base_addr = b; length = l; seed = s; step = st; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; loads = 0; seen_done = 1'b0; aborted = 1'b0;
    if (el > 0) begin
      check({tag, " first busy"}, {31'd0, busy}, 32'd1);
      check({tag, " first addr"}, {26'd0, ram_address}, {26'd0, b});
      check({tag, " first data"}, {16'd0, ram_in}, {16'd0, s});
    end
    while (!seen_done && !aborted && cyc <= 300) begin
      if (ram_load) loads++;
      check({tag, " busy/done exclusive"}, {31'd0, busy & done}, 32'd0);
      if (rst_at >= 0 && cyc == rst_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check({tag, " rst load"}, {31'd0, ram_load}, 32'd0);
        check({tag, " rst busy"}, {31'd0, busy}, 32'd0);
        check({tag, " rst done"}, {31'd0, done}, 32'd0);
        check({tag, " rst addr"}, {26'd0, ram_address}, 32'd0);
        check({tag, " rst data"}, {16'd0, ram_in}, 32'd0);
        check({tag, " rst state"}, {30'd0, dut.state}, {30'd0, S_IDLE});
        aborted = 1'b1;
      end else if (done) begin
        seen_done = 1'b1;
        check({tag, " latency"}, cyc, lat);
        check({tag, " loads"}, loads, el);
        check({tag, " err"}, {31'd0, err}, {31'd0, mism > 0});
        check({tag, " count"}, {25'd0, mismatch_count}, exp_cnt);
      end else begin
        if (poke && cyc == 3) begin
          base_addr = 6'd33; length = 7'd5; seed = 16'hDEAD; start = 1'b1;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    check({tag, " finished"}, {31'd0, seen_done | aborted}, 32'd1);
    @(negedge clk);
    check({tag, " idle busy"}, {31'd0, busy}, 32'd0);
    check({tag, " idle done"}, {31'd0, done}, 32'd0);
    check_mem(tag);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; seed = '0; step = '0;
    clear_mem = 1'b1; inject = 1'b0;
    for (int i = 0; i < 64; i++) exp_mem[i] = 16'h0000;
    repeat (3) @(negedge clk);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset load", {31'd0, ram_load}, 32'd0);
    check("reset addr", {26'd0, ram_address}, 32'd0);
    check("reset data", {16'd0, ram_in}, 32'd0);
    check("reset err", {31'd0, err}, 32'd0);
    check("reset count", {25'd0, mismatch_count}, 32'd0);
    check("reset state", {30'd0, dut.state}, {30'd0, S_IDLE});
    reset = 1'b0; clear_mem = 1'b0;

    run_op("full fill", 6'd0, 7'd64, 16'h5A5A, 16'h0001, 1'b0, -1);
    run_op("wrap", 6'd62, 7'd4, 16'hFFFE, 16'h0001, 1'b0, -1);
    run_op("len0", 6'd5, 7'd0, 16'h1234, 16'h0007, 1'b0, -1);
    run_op("len100", 6'd10, 7'd100, 16'hABCD, 16'h0003, 1'b0, -1);
    run_op("verify clean", 6'd0, 7'd8, 16'h1000, 16'h0011, 1'b0, -1);
    inject = 1'b1;
    run_op("verify fault", 6'd0, 7'd8, 16'h2000, 16'h0101, 1'b0, -1);
    inject = 1'b0;
    run_op("after fault", 6'd0, 7'd8, 16'h3000, 16'h0002, 1'b0, -1);
    run_op("start ignored", 6'd20, 7'd30, 16'h0F0F, 16'h1111, 1'b1, -1);
    run_op("mid reset", 6'd40, 7'd20, 16'h7700, 16'h0040, 1'b0, 10);

    for (int n = 0; n < 8; n++) begin
      inject = ($urandom_range(0, 2) == 0);
      run_op($sformatf("rand%0d", n), 6'($urandom_range(0, 63)), 7'($urandom_range(0, 100)),
             16'($urandom), 16'($urandom), 1'b0, -1);
    end
    inject = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
